ball_locate: RTL and testbench
==============================

BALL_LOCATE -- requirements
Module: ball_locate

Interface
REQ-001 Parameter H_ACT, 640, active pixels per line; pixels at x >= H_ACT are ignored.
REQ-002 Parameter V_ACT, 480, active lines per frame; lines at y >= V_ACT are ignored.
REQ-003 Parameter RUN_MIN, 4, consecutive white pixels in a line required before the run counts (noise filter, range 1..15).
REQ-004 Parameter PIX_MIN, 64, minimum accepted pixels for a frame to report found.
REQ-005 clk  in  1  pixel clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 bin_vsync  in  1  frame sync from binarization stage, active-high; rising edge marks frame start.
REQ-008 bin_hsync  in  1  line sync; carried for timing only, not used for counting.
REQ-009 bin_de  in  1  active-pixel enable.
REQ-010 monoc  in  1  binary pixel, 1 = target colour, sampled only when bin_de = 1.
REQ-011 box_valid  out  1  one-cycle pulse: result registers updated.
REQ-012 box_found  out  1  1 when the last completed frame had pix_cnt >= PIX_MIN.
REQ-013 x_min, x_max  out  11 each  horizontal bounding box of accepted pixels.
REQ-014 y_min, y_max  out  11 each  vertical bounding box of accepted pixels.
REQ-015 center_x, center_y  out  11 each  (min+max)>>1, computed with a 12-bit sum.
REQ-016 pix_cnt  out  20  accepted-pixel count of the last completed frame.

Function
REQ-017 x counter: 0 on first de=1 cycle of a line, +1 per de=1 cycle, saturates at 2047, cleared when de=0.
REQ-018 y counter: cleared at vsync rising edge, +1 on every de falling edge, saturates at 2047.
REQ-019 Run counter (4 bits): +1 per white in-range pixel, saturating at RUN_MIN; cleared by black pixel, de=0, or x >= H_ACT.
REQ-020 Pixel accepted when white, in range, and run counter (after increment) >= RUN_MIN.
REQ-021 On the cycle run reaches RUN_MIN, x_min update uses x-(RUN_MIN-1) (run start); x_max uses current x.
REQ-022 Accumulators per frame: acc_xmin/acc_ymin reset to 2047, acc_xmax/acc_ymax reset to 0, acc_cnt to 0; acc_cnt saturates at 2^20-1; acc_cnt adds RUN_MIN on the first accepted pixel of a run and 1 thereafter.
REQ-023 FSM states WAIT_FRAME, SCAN; reset enters WAIT_FRAME; first vsync rising edge -> SCAN, clears accumulators, no box_valid (partial frame discarded).
REQ-024 In SCAN, each vsync rising edge: copy accumulators to outputs, set box_found, pulse box_valid the next cycle, clear accumulators in the same cycle as the copy; stay in SCAN.
REQ-025 Latency: box_valid asserts 2 clk after the vsync rising-edge sample cycle; outputs stable until next box_valid.
REQ-026 If box_found = 0, coordinate outputs and centers are forced to 0, pix_cnt still reports count.
REQ-027 A pixel arriving in the same cycle as the vsync rising edge belongs to the new frame.
REQ-028 de asserted while vsync high is processed normally (no gating by vsync level).

Reset
REQ-029 Asynchronous rst_n low: all outputs 0, counters 0, accumulators to their clear values, FSM WAIT_FRAME; reset mid-frame discards that frame.

Structure
REQ-030 Shared package holds coordinate width (11), count width (20), saturation constants, and FSM state encoding.
REQ-031 One sub-module, run_filter, implements REQ-019..021 (run counter, accept flag, run-start x).

Verification
REQ-032 Frame 640x480 all black -> box_valid pulse, box_found=0, pix_cnt=0, coords 0.
REQ-033 White square x 100..149, y 200..249 -> x_min=100, x_max=149, y_min=200, y_max=249, center (124,224), pix_cnt=2500, box_found=1.
REQ-034 Isolated white runs of 3 pixels scattered, RUN_MIN=4 -> pix_cnt=0, box_found=0.
REQ-035 First frame after reset containing square -> no box_valid; second frame reports it.
REQ-036 White at x 630..700 on line 10 with H_ACT=640 -> x_max=639, pix_cnt=10 (single line, PIX_MIN=8 override).
REQ-037 rst_n pulsed low mid-frame -> outputs zero immediately, next vsync gives no box_valid.

Source files
------------

// File: rtl/ball_locate_pkg.sv
// Shared widths, saturation limits and FSM encoding for the ball locator.
// Pure definitions: no latency, no backpressure.
package ball_locate_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 20;
  localparam int RUN_W   = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam coord_t COORD_MAX = '1;
  localparam cnt_t   CNT_MAX   = '1;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    SCAN       = 1'b1
  } state_t;

  function automatic coord_t coord_inc(input coord_t v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ball_locate_run_filter.sv
// Run-length noise filter: accept flag, first-of-run flag and run-start x.
// Combinational accept in the pixel's own cycle; no backpressure (streaming).
module ball_locate_run_filter
  import ball_locate_pkg::*;
#(
  parameter int H_ACT   = 640,
  parameter int RUN_MIN = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_de,
  input  logic   i_pix,
  input  logic   i_y_ok,
  input  coord_t i_x,
  output logic   o_accept,
  output logic   o_first,
  output coord_t o_x_start
);

  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(RUN_MIN);

  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_white;

  assign w_white   = i_de & i_pix & i_y_ok & (i_x < COORD_W'(H_ACT));
  assign w_run_inc = (r_run >= RUN_LIM) ? RUN_LIM : r_run + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= '0;
    else        r_run <= w_white ? w_run_inc : '0;
  end

  assign o_accept  = w_white & (w_run_inc >= RUN_LIM);
  // The pixel that completes the run vouches for the RUN_MIN-1 pixels before it.
  assign o_first   = o_accept & (r_run < RUN_LIM);
  assign o_x_start = o_first ? i_x - COORD_W'(RUN_MIN - 1) : i_x;

endmodule

// File: rtl/ball_locate.sv
// Bounding box, centre and pixel count of target-colour runs per video frame.
// Result pulses 2 clk after the vsync rise is sampled; no backpressure (streaming).
module ball_locate
  import ball_locate_pkg::*;
#(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int RUN_MIN = 4,
  parameter int PIX_MIN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bin_vsync,
  input  logic               bin_hsync,
  input  logic               bin_de,
  input  logic               monoc,
  output logic               box_valid,
  output logic               box_found,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [CNT_W-1:0]   pix_cnt
);

  logic   w_unused_hsync;
  logic   r_vs_d, r_de_d;
  coord_t r_x, r_y;
  logic   w_vs_rise, w_de_fall, w_y_ok;
  coord_t w_y;
  logic   w_accept, w_first;
  coord_t w_x_start;

  assign w_unused_hsync = bin_hsync;
  assign w_vs_rise      = bin_vsync & ~r_vs_d;
  assign w_de_fall      = r_de_d & ~bin_de;
  // A pixel in the vsync-rise cycle already belongs to line 0 of the new frame.
  assign w_y            = w_vs_rise ? '0 : r_y;
  assign w_y_ok         = (w_y < COORD_W'(V_ACT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_vs_d <= bin_vsync;
      r_de_d <= bin_de;
      r_x    <= bin_de ? coord_inc(r_x) : '0;
      if (w_vs_rise)      r_y <= '0;
      else if (w_de_fall) r_y <= coord_inc(r_y);
    end
  end

  ball_locate_run_filter #(
    .H_ACT   (H_ACT),
    .RUN_MIN (RUN_MIN)
  ) u_run_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_de      (bin_de),
    .i_pix     (monoc),
    .i_y_ok    (w_y_ok),
    .i_x       (r_x),
    .o_accept  (w_accept),
    .o_first   (w_first),
    .o_x_start (w_x_start)
  );

  coord_t           r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
  cnt_t             r_acc_cnt;
  coord_t           w_base_xmin, w_base_xmax, w_base_ymin, w_base_ymax;
  cnt_t             w_base_cnt, w_cnt_add;
  logic [CNT_W:0]   w_cnt_sum;
  coord_t           w_nxt_xmin, w_nxt_xmax, w_nxt_ymin, w_nxt_ymax;
  cnt_t             w_nxt_cnt;

  // Frame boundary: start from cleared values so the boundary pixel lands in the new frame.
  assign w_base_xmin = w_vs_rise ? COORD_MAX : r_acc_xmin;
  assign w_base_xmax = w_vs_rise ? '0        : r_acc_xmax;
  assign w_base_ymin = w_vs_rise ? COORD_MAX : r_acc_ymin;
  assign w_base_ymax = w_vs_rise ? '0        : r_acc_ymax;
  assign w_base_cnt  = w_vs_rise ? '0        : r_acc_cnt;
  assign w_cnt_add   = w_first ? CNT_W'(RUN_MIN) : CNT_W'(1);
  assign w_cnt_sum   = {1'b0, w_base_cnt} + {1'b0, w_cnt_add};

  always_comb begin
    w_nxt_xmin = w_base_xmin;
    w_nxt_xmax = w_base_xmax;
    w_nxt_ymin = w_base_ymin;
    w_nxt_ymax = w_base_ymax;
    w_nxt_cnt  = w_base_cnt;
    if (w_accept) begin
      if (w_x_start < w_base_xmin) w_nxt_xmin = w_x_start;
      if (r_x > w_base_xmax)       w_nxt_xmax = r_x;
      if (w_y < w_base_ymin)       w_nxt_ymin = w_y;
      if (w_y > w_base_ymax)       w_nxt_ymax = w_y;
      w_nxt_cnt = w_cnt_sum[CNT_W] ? CNT_MAX : w_cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_xmin <= COORD_MAX;
      r_acc_xmax <= '0;
      r_acc_ymin <= COORD_MAX;
      r_acc_ymax <= '0;
      r_acc_cnt  <= '0;
    end else begin
      r_acc_xmin <= w_nxt_xmin;
      r_acc_xmax <= w_nxt_xmax;
      r_acc_ymin <= w_nxt_ymin;
      r_acc_ymax <= w_nxt_ymax;
      r_acc_cnt  <= w_nxt_cnt;
    end
  end

  state_t              r_state;
  logic                r_snap_go;
  coord_t              r_snap_xmin, r_snap_xmax, r_snap_ymin, r_snap_ymax;
  cnt_t                r_snap_cnt;
  logic                w_snap_found;
  logic [COORD_W:0]    w_sum_x, w_sum_y;
  logic                r_box_valid, r_box_found;
  coord_t              r_x_min, r_x_max, r_y_min, r_y_max, r_cx, r_cy;
  cnt_t                r_pix_cnt;

  assign w_snap_found = (r_snap_cnt >= CNT_W'(PIX_MIN));
  assign w_sum_x      = {1'b0, r_snap_xmin} + {1'b0, r_snap_xmax};
  assign w_sum_y      = {1'b0, r_snap_ymin} + {1'b0, r_snap_ymax};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_FRAME;
      r_snap_go   <= 1'b0;
      r_snap_xmin <= '0;
      r_snap_xmax <= '0;
      r_snap_ymin <= '0;
      r_snap_ymax <= '0;
      r_snap_cnt  <= '0;
      r_box_valid <= 1'b0;
      r_box_found <= 1'b0;
      r_x_min     <= '0;
      r_x_max     <= '0;
      r_y_min     <= '0;
      r_y_max     <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_pix_cnt   <= '0;
    end else begin
      r_snap_go   <= 1'b0;
      r_box_valid <= 1'b0;
      case (r_state)
        // The frame in progress at reset release is partial; only arm on its end.
        WAIT_FRAME: if (w_vs_rise) r_state <= SCAN;
        SCAN: if (w_vs_rise) begin
          r_snap_go   <= 1'b1;
          r_snap_xmin <= r_acc_xmin;
          r_snap_xmax <= r_acc_xmax;
          r_snap_ymin <= r_acc_ymin;
          r_snap_ymax <= r_acc_ymax;
          r_snap_cnt  <= r_acc_cnt;
        end
        default: r_state <= WAIT_FRAME;
      endcase
      if (r_snap_go) begin
        r_box_valid <= 1'b1;
        r_box_found <= w_snap_found;
        r_x_min     <= w_snap_found ? r_snap_xmin : '0;
        r_x_max     <= w_snap_found ? r_snap_xmax : '0;
        r_y_min     <= w_snap_found ? r_snap_ymin : '0;
        r_y_max     <= w_snap_found ? r_snap_ymax : '0;
        r_cx        <= w_snap_found ? w_sum_x[COORD_W:1] : '0;
        r_cy        <= w_snap_found ? w_sum_y[COORD_W:1] : '0;
        r_pix_cnt   <= r_snap_cnt;
      end
    end
  end

  assign box_valid = r_box_valid;
  assign box_found = r_box_found;
  assign x_min     = r_x_min;
  assign x_max     = r_x_max;
  assign y_min     = r_y_min;
  assign y_max     = r_y_max;
  assign center_x  = r_cx;
  assign center_y  = r_cy;
  assign pix_cnt   = r_pix_cnt;

endmodule

// File: tb/tb_ball_locate.sv
// Directed frames with a scoreboard of expected per-frame results; PIX_MIN lowered to 8.
module tb_ball_locate;

  logic        clk = 1'b0;
  logic        rst_n, vs, hs, de, mono;
  logic        box_valid, box_found;
  logic [10:0] x_min, x_max, y_min, y_max, center_x, center_y;
  logic [19:0] pix_cnt;

  ball_locate #(.PIX_MIN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_vsync (vs),
    .bin_hsync (hs),
    .bin_de    (de),
    .monoc     (mono),
    .box_valid (box_valid),
    .box_found (box_found),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max),
    .center_x  (center_x),
    .center_y  (center_y),
    .pix_cnt   (pix_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        found;
    logic [10:0] xmin, xmax, ymin, ymax, cx, cy;
    logic [19:0] cnt;
    int          drive_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0, n_fail = 0, n_total = 0;
  int   n_valid = 0, n_push = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic f, input int xmn, input int xmx,
                              input int ymn, input int ymx, input int cnt);
    exp_t e;
    e.found     = f;
    e.cnt       = 20'(cnt);
    e.xmin      = f ? 11'(xmn) : 11'd0;
    e.xmax      = f ? 11'(xmx) : 11'd0;
    e.ymin      = f ? 11'(ymn) : 11'd0;
    e.ymax      = f ? 11'(ymx) : 11'd0;
    e.cx        = f ? 11'((xmn + xmx) / 2) : 11'd0;
    e.cy        = f ? 11'((ymn + ymx) / 2) : 11'd0;
    e.drive_cyc = 0;
    return e;
  endfunction

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (rst_n && box_valid) begin
      n_valid++;
      if (sb.size() == 0) check("unexpected_box_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("box_found", box_found, e.found);
        check("x_min", x_min, e.xmin);
        check("x_max", x_max, e.xmax);
        check("y_min", y_min, e.ymin);
        check("y_max", y_max, e.ymax);
        check("center_x", center_x, e.cx);
        check("center_y", center_y, e.cy);
        check("pix_cnt", pix_cnt, e.cnt);
        check("latency", cyc - e.drive_cyc, 2);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de = 1'b0; mono = 1'b0;
    end
  endtask

  task automatic line(input int w, input int lo, input int hi);
    for (int x = 0; x < w; x++) begin
      @(negedge clk);
      de = 1'b1; mono = (x >= lo && x <= hi);
    end
    @(negedge clk);
    de = 1'b0; mono = 1'b0; hs = 1'b1;
    @(negedge clk);
    hs = 1'b0;
  endtask

  task automatic frame_end(input logic want, input exp_t e_in);
    exp_t e;
    e = e_in;
    @(negedge clk);
    vs = 1'b1;
    e.drive_cyc = cyc;
    if (want) begin
      sb.push_back(e);
      n_push++;
    end
    repeat (2) @(negedge clk);
    vs = 1'b0;
    idle(4);
  endtask

  task automatic square_frame();
    for (int y = 0; y < 250; y++) begin
      if (y < 200) line(1, 1, 0);
      else         line(150, 100, 149);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, box_valid, 0);
    check({tag, "_found"}, box_found, 0);
    check({tag, "_x_min"}, x_min, 0);
    check({tag, "_x_max"}, x_max, 0);
    check({tag, "_y_min"}, y_min, 0);
    check({tag, "_y_max"}, y_max, 0);
    check({tag, "_center_x"}, center_x, 0);
    check({tag, "_center_y"}, center_y, 0);
    check({tag, "_pix_cnt"}, pix_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0; mono = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Partial frame after reset: its end must not report.
    square_frame();
    frame_end(1'b0, mk(0, 0, 0, 0, 0, 0));
    square_frame();
    frame_end(1'b1, mk(1, 100, 149, 200, 249, 2500));

    repeat (8) line(20, 1, 0);
    frame_end(1'b1, mk(0, 0, 0, 0, 0, 0));

    line(40, 5, 7);
    line(40, 10, 12);
    line(40, 30, 32);
    line(40, 0, 2);
    line(3, 0, 2);
    frame_end(1'b1, mk(0, 0, 0, 0, 0, 0));

    repeat (5) line(4, 1, 0);
    line(40, 20, 26);
    frame_end(1'b1, mk(0, 0, 0, 0, 0, 7));

    repeat (3) line(4, 1, 0);
    line(40, 20, 27);
    frame_end(1'b1, mk(1, 20, 27, 3, 3, 8));

    repeat (10) line(4, 1, 0);
    line(701, 630, 700);
    frame_end(1'b1, mk(1, 630, 639, 10, 10, 10));

    line(40, 20, 27);
    repeat (5) begin
      @(negedge clk);
      de = 1'b1; mono = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1; de = 1'b0; mono = 1'b0;
    idle(2);
    line(40, 20, 27);
    frame_end(1'b0, mk(0, 0, 0, 0, 0, 0));
    line(40, 20, 27);
    frame_end(1'b1, mk(1, 20, 27, 0, 0, 8));

    idle(10);
    check("valid_count", n_valid, n_push);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
